// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// The cache is the slave; the fetcher/memory environment is the master.
interface icache_if;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic        hit;
  logic [31:0] hit_inst;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_done;
  logic [31:0] mc_data;

  modport slave (
    input  rd_en, rd_addr, mc_done, mc_data,
    output hit, hit_inst, mc_req, mc_addr
  );

  modport master (
    output rd_en, rd_addr, mc_done, mc_data,
    input  hit, hit_inst, mc_req, mc_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational lookup,
// 4-word line refill over a word-at-a-time request/done handshake.
module icache #(
  parameter int unsigned IDX_W = 6
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  icache_if.slave  bus
);
  localparam int unsigned TAG_W = 28 - IDX_W;
  localparam int unsigned LINES = 1 << IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t state, state_next;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES][4];

  // Line being refilled, as {tag, index}
  logic [27:0] fill_line, fill_line_next;
  logic [1:0]  cnt, cnt_next;
  logic        req_q, req_next;
  logic [31:0] addr_q, addr_next;

  logic start_c, word_wr_c, line_done_c;

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [1:0]       rd_word;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             hit_c;
  logic             unused_ok;

  assign rd_word  = bus.rd_addr[3:2];
  assign rd_idx   = bus.rd_addr[3+IDX_W:4];
  assign rd_tag   = bus.rd_addr[31:4+IDX_W];
  assign fill_idx = fill_line[IDX_W-1:0];
  assign fill_tag = fill_line[27:IDX_W];
  assign unused_ok = &{1'b0, bus.rd_addr[1:0]};

  // Lookup is independent of the refill state
  assign hit_c        = bus.rd_en && valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign bus.hit      = hit_c;
  assign bus.hit_inst = hit_c ? data_mem[rd_idx][rd_word] : 32'h0;
  assign bus.mc_req   = req_q;
  assign bus.mc_addr  = addr_q;

  // Next-state and refill control; nothing advances while rdy is low
  always_comb begin
    state_next     = state;
    fill_line_next = fill_line;
    cnt_next       = cnt;
    req_next       = req_q;
    addr_next      = addr_q;
    start_c        = 1'b0;
    word_wr_c      = 1'b0;
    line_done_c    = 1'b0;
    if (rdy) begin
      case (state)
        IDLE: begin
          if (bus.rd_en && !hit_c) begin
            state_next     = FILL;
            fill_line_next = bus.rd_addr[31:4];
            cnt_next       = 2'd0;
            req_next       = 1'b1;
            addr_next      = {bus.rd_addr[31:4], 4'h0};
            start_c        = 1'b1;
          end
        end
        FILL: begin
          if (bus.mc_done) begin
            word_wr_c = 1'b1;
            if (cnt == 2'd3) begin
              line_done_c = 1'b1;
              req_next    = 1'b0;
              state_next  = IDLE;
            end else begin
              cnt_next  = cnt + 2'd1;
              addr_next = addr_q + 32'd4;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      fill_line <= '0;
      cnt       <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
    end else begin
      state     <= state_next;
      fill_line <= fill_line_next;
      cnt       <= cnt_next;
      req_q     <= req_next;
      addr_q    <= addr_next;
      // The target line stays invalid until its last word lands
      if (start_c) valid[rd_idx] <= 1'b0;
      if (line_done_c) begin
        valid[fill_idx]   <= 1'b1;
        tag_mem[fill_idx] <= fill_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && word_wr_c) data_mem[fill_idx][cnt] <= bus.mc_data;
  end
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed refill sequences, a vector table
// and randomized traffic checked against a line-level reference model.
module tb_icache;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned LINES = 1 << IDX_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;

  icache_if bus ();

  icache #(.IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  auto_resp = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic        en;
    logic        hit;
    logic [31:0] inst;
  } vec_t;

  vec_t tbl [11];

  // Backing memory contents; line 0x100 holds the documented 0x11..0x44 pattern
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w[31:4] == 28'h10) return 32'h11 * (32'(w[3:2]) + 32'd1);
    return (w * 32'h9E37_79B9) ^ 32'h5BD1_E995;
  endfunction

  function automatic int unsigned line_of(input logic [31:0] a);
    return int'(a[3+IDX_W:4]);
  endfunction

  // Reference model: which memory line each cache slot holds, and the refill in flight
  bit          m_valid [LINES];
  logic [27:0] m_slot  [LINES];
  bit          m_filling = 1'b0;
  logic [27:0] m_line = '0;
  int          m_words = 0;
  bit          model_ok = 1'b0;

  function automatic bit m_hit(input logic en, input logic [31:0] a);
    return en && m_valid[line_of(a)] && (m_slot[line_of(a)] == a[31:4]);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(LINES); i++) m_valid[i] <= 1'b0;
      m_filling <= 1'b0;
      m_line    <= '0;
      m_words   <= 0;
      model_ok  <= 1'b1;
    end else if (rdy) begin
      if (!m_filling) begin
        if (bus.rd_en && !m_hit(bus.rd_en, bus.rd_addr)) begin
          m_filling                    <= 1'b1;
          m_line                       <= bus.rd_addr[31:4];
          m_words                      <= 0;
          m_valid[line_of(bus.rd_addr)] <= 1'b0;
        end
      end else if (bus.mc_done) begin
        if (m_words == 3) begin
          m_filling                              <= 1'b0;
          m_valid[line_of({m_line, 4'h0})]       <= 1'b1;
          m_slot[line_of({m_line, 4'h0})]        <= m_line;
        end else begin
          m_words <= m_words + 1;
        end
      end
    end
  end

  task automatic expect32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic [65:0] act, exp;
    logic        eh;
    if (!model_ok) return;
    eh  = m_hit(bus.rd_en, bus.rd_addr);
    exp = {eh, eh ? mem_word(bus.rd_addr) : 32'h0, m_filling,
           {m_line, 4'h0} + 32'(m_words) * 32'd4};
    act = {bus.hit, bus.hit_inst, bus.mc_req, bus.mc_addr};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model t=%0t addr=0x%08h: got {hit,inst,req,addr}=%h expected %h",
               $time, bus.rd_addr, act, exp);
    end
  endtask

  // One clock: compare against the model, cross the edge, then drive the responder
  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    #1;
    if (auto_resp) begin
      bus.mc_done = bus.mc_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 24) == 0);
      bus.mc_data = mem_word(bus.mc_addr);
    end
  endtask

  task automatic give_word();
    bus.mc_done = 1'b1;
    bus.mc_data = mem_word(bus.mc_addr);
    tick();
    bus.mc_done = 1'b0;
    bus.mc_data = '0;
  endtask

  task automatic look(input logic en, input logic [31:0] a);
    bus.rd_en   = en;
    bus.rd_addr = a;
    #1;
  endtask

  task automatic fill_line(input logic [31:0] a);
    look(1'b1, a);
    tick();
    bus.rd_en = 1'b0;
    repeat (4) give_word();
  endtask

  initial begin
    tbl[0]  = '{32'h0000_0100, 1'b1, 1'b1, 32'h11};
    tbl[1]  = '{32'h0000_0104, 1'b1, 1'b1, 32'h22};
    tbl[2]  = '{32'h0000_010B, 1'b1, 1'b1, 32'h33};
    tbl[3]  = '{32'h0000_010C, 1'b1, 1'b1, 32'h44};
    tbl[4]  = '{32'h0000_0104, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{32'h0000_0500, 1'b1, 1'b0, 32'h0};
    tbl[6]  = '{32'h0000_0110, 1'b1, 1'b0, 32'h0};
    tbl[7]  = '{32'h0000_05A0, 1'b1, 1'b1, mem_word(32'h5A0)};
    tbl[8]  = '{32'h0000_05AD, 1'b1, 1'b1, mem_word(32'h5AC)};
    tbl[9]  = '{32'h0000_01A0, 1'b1, 1'b0, 32'h0};
    tbl[10] = '{32'hFFFF_FF04, 1'b1, 1'b0, 32'h0};

    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.mc_done = 1'b0; bus.mc_data = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state and first miss
    expect32("reset mc_req", 32'(bus.mc_req), 32'd0);
    expect32("reset mc_addr", bus.mc_addr, 32'd0);
    look(1'b1, 32'h0);
    expect32("reset hit", 32'(bus.hit), 32'd0);
    expect32("reset hit_inst", bus.hit_inst, 32'd0);
    tick();
    expect32("first mc_req", 32'(bus.mc_req), 32'd1);
    expect32("first mc_addr", bus.mc_addr, 32'd0);
    bus.rd_en = 1'b0;
    repeat (4) give_word();
    rst = 1'b1; tick(); rst = 1'b0;

    // Cold miss at 0x104 with back-to-back words
    look(1'b1, 32'h104);
    expect32("cold miss hit", 32'(bus.hit), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      expect32("cold mc_req", 32'(bus.mc_req), 32'd1);
      expect32("cold mc_addr", bus.mc_addr, 32'h100 + 32'(i) * 32'd4);
      give_word();
    end
    expect32("cold mc_req fall", 32'(bus.mc_req), 32'd0);
    look(1'b1, 32'h104);
    expect32("cold hit 104", 32'(bus.hit), 32'd1);
    expect32("cold inst 104", bus.hit_inst, 32'h22);
    look(1'b1, 32'h10C);
    expect32("cold inst 10c", bus.hit_inst, 32'h44);

    // Conflict on the same index
    look(1'b1, 32'h100 + (32'd16 << IDX_W));
    expect32("conflict miss", 32'(bus.hit), 32'd0);
    tick();
    expect32("conflict mc_addr", bus.mc_addr, 32'h500);
    bus.rd_en = 1'b0;
    repeat (4) give_word();
    look(1'b1, 32'h500);
    expect32("conflict new hit", 32'(bus.hit), 32'd1);
    look(1'b1, 32'h100);
    expect32("conflict evicted", 32'(bus.hit), 32'd0);

    // Address changes mid-fill; the latched line completes first
    tick();
    give_word();
    bus.rd_addr = 32'h200;
    for (int i = 1; i < 4; i++) begin
      expect32("midfill mc_addr", bus.mc_addr, 32'h100 + 32'(i) * 32'd4);
      give_word();
    end
    expect32("midfill req fall", 32'(bus.mc_req), 32'd0);
    #1;
    expect32("midfill 200 miss", 32'(bus.hit), 32'd0);
    tick();
    expect32("second fill req", 32'(bus.mc_req), 32'd1);
    expect32("second fill addr", bus.mc_addr, 32'h200);
    bus.rd_en = 1'b0;
    repeat (4) give_word();
    look(1'b1, 32'h104);
    expect32("midfill 104 inst", bus.hit_inst, 32'h22);

    // rdy held low between words
    look(1'b1, 32'h300);
    tick();
    bus.rd_en = 1'b0;
    give_word();
    rdy = 1'b0;
    repeat (3) begin
      tick();
      expect32("freeze mc_addr", bus.mc_addr, 32'h304);
      expect32("freeze mc_req", 32'(bus.mc_req), 32'd1);
    end
    rdy = 1'b1;
    repeat (3) give_word();
    expect32("freeze req fall", 32'(bus.mc_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      look(1'b1, 32'h300 + 32'(i) * 32'd4);
      expect32("freeze line data", bus.hit_inst, mem_word(32'h300 + 32'(i) * 32'd4));
    end

    // Reset after the second word of a fill
    look(1'b1, 32'h400);
    tick();
    bus.rd_en = 1'b0;
    repeat (2) give_word();
    rst = 1'b1;
    tick();
    expect32("rst mc_req", 32'(bus.mc_req), 32'd0);
    expect32("rst mc_addr", bus.mc_addr, 32'd0);
    rst = 1'b0;
    look(1'b1, 32'h400);
    expect32("rst partial line", 32'(bus.hit), 32'd0);
    look(1'b1, 32'h300);
    expect32("rst old line 300", 32'(bus.hit), 32'd0);
    look(1'b1, 32'h104);
    expect32("rst old line 104", 32'(bus.hit), 32'd0);
    bus.rd_en = 1'b0;

    // Vector table against two filled lines; rdy low keeps misses from refilling
    fill_line(32'h100);
    fill_line(32'h5A0);
    rdy = 1'b0;
    for (int i = 0; i < 11; i++) begin
      look(tbl[i].en, tbl[i].addr);
      expect32($sformatf("tbl[%0d] hit", i), 32'(bus.hit), 32'(tbl[i].hit));
      expect32($sformatf("tbl[%0d] inst", i), bus.hit_inst, tbl[i].inst);
    end
    rdy = 1'b1;
    bus.rd_en = 1'b0;
    tick();

    // Randomized traffic over a few conflicting lines
    auto_resp = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      rdy         = ($urandom_range(0, 9) != 0);
      rst         = ($urandom_range(0, 299) == 0);
      bus.rd_en   = ($urandom_range(0, 3) != 0);
      bus.rd_addr = (32'($urandom_range(0, 3)) << (4 + IDX_W)) |
                    (32'($urandom_range(0, 7)) << 4) |
                    32'($urandom_range(0, 15));
      tick();
    end
    auto_resp   = 1'b0;
    bus.mc_done = 1'b0;
    rst         = 1'b0;
    rdy         = 1'b1;
    bus.rd_en   = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
